data_memory_responder: RTL and testbench

- Responder side of the core's data-memory interface: a word-organised data RAM behind a valid/ready request channel and a valid/ready response channel.
- Accepts one load or store at a time and inserts a programmable number of wait states.
- Supports byte-enabled stores and flags misaligned or out-of-range accesses.
- Used as the memory slave for the multi-cycle core variant, and as a bus responder model in core-level benches.

---
 rtl/data_memory_responder.sv | 123 ++++++++++++
 tb/tb_data_memory_responder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
// Word-organised data RAM behind a valid/ready request and a valid/ready response channel.
// One access in flight at a time, with WAIT_CYCLES wait states between accept and array access.
module data_memory_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_be_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_error_o
);

  // Handshakes: a request transfers on an edge where req_valid_i & req_ready_o;
  // a response transfers on an edge where rsp_valid_o & rsp_ready_i.
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_e;

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_INIT = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [31:0] rdata_q, rdata_d;
  logic        error_q, error_d;

  logic [31:0] mem_q [DEPTH];

  logic        accept;
  logic        access_err;
  logic [29:0] word_addr;
  logic [AW-1:0] idx;

  assign accept     = req_valid_i && req_ready_o;
  assign word_addr  = addr_q[31:2];
  assign idx        = word_addr[AW-1:0];
  // No wrap-around: any word index beyond the array is an error, as is any misalignment.
  assign access_err = (addr_q[1:0] != 2'b00) || ({2'b00, word_addr} >= 32'(DEPTH));

  // State register
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
      S_WAIT:   if (cnt_q == 4'd0) state_d = S_ACCESS;
      S_ACCESS: state_d = S_RESP;
      S_RESP:   if (rsp_ready_i) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready_o = (state_q == S_IDLE) && !reset_i;
    rsp_valid_o = (state_q == S_RESP);
    rsp_rdata_o = rdata_q;
    rsp_error_o = error_q;
  end

  // Wait counter and response registers
  always_comb begin
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    error_d = error_q;
    if (accept) cnt_d = WAIT_INIT;
    else if (state_q == S_WAIT && cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
    if (state_q == S_ACCESS) begin
      rdata_d = (!write_q && !access_err) ? mem_q[idx] : 32'd0;
      error_d = access_err;
    end else if (state_q == S_RESP && rsp_ready_i) begin
      rdata_d = 32'd0;
      error_d = 1'b0;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      error_q <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
    end else begin
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
      if (accept) begin
        write_q <= req_write_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        be_q    <= req_be_i;
      end
    end
  end

  // Array contents survive reset; a reset during ACCESS forces IDLE and so suppresses the write.
  always_ff @(posedge clock_i) begin
    if (state_q == S_ACCESS && write_q && !access_err) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem_q[idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: one instance with two wait states, one with none.
module tb_data_memory_responder;

  localparam int LIMIT = 40;

  logic        clk;
  logic        rst;

  logic        a_req_valid, a_req_ready, a_req_write, a_rsp_valid, a_rsp_ready, a_rsp_error;
  logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
  logic [3:0]  a_req_be;

  logic        b_req_valid, b_req_ready, b_req_write, b_rsp_valid, b_rsp_ready, b_rsp_error;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
  logic [3:0]  b_req_be;

  int n_cmp = 0;
  int n_mis = 0;
  logic [31:0] exp_q[$];

  data_memory_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dut (
    .clock_i(clk), .reset_i(rst),
    .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_write_i(a_req_write),
    .req_addr_i(a_req_addr), .req_wdata_i(a_req_wdata), .req_be_i(a_req_be),
    .rsp_valid_o(a_rsp_valid), .rsp_ready_i(a_rsp_ready),
    .rsp_rdata_o(a_rsp_rdata), .rsp_error_o(a_rsp_error)
  );

  data_memory_responder #(.DEPTH(256), .WAIT_CYCLES(0)) dut0 (
    .clock_i(clk), .reset_i(rst),
    .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_write_i(b_req_write),
    .req_addr_i(b_req_addr), .req_wdata_i(b_req_wdata), .req_be_i(b_req_be),
    .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready),
    .rsp_rdata_o(b_rsp_rdata), .rsp_error_o(b_rsp_error)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Full transaction on the WAIT_CYCLES=2 instance; entered and left at a negedge.
  task automatic do_req(input string tag, input logic w, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    exp_q.push_back(exp_rdata);
    a_req_write = w; a_req_addr = addr; a_req_wdata = wdata; a_req_be = be;
    a_req_valid = 1'b1; a_rsp_ready = 1'b1;
    n = 0;
    while (!a_req_ready && n < LIMIT) begin @(negedge clk); n++; end
    check({tag, "_accept"}, 32'(n < LIMIT), 32'd1);
    @(posedge clk);
    @(negedge clk);
    a_req_valid = 1'b0;
    n = 0;
    while (!a_rsp_valid && n < LIMIT) begin @(negedge clk); n++; end
    check({tag, "_latency"}, 32'(n), 32'd3);
    check({tag, "_rdata"}, a_rsp_rdata, exp_q.pop_front());
    check({tag, "_error"}, 32'(a_rsp_error), 32'(exp_err));
    @(negedge clk);
    check({tag, "_valid_drop"}, 32'(a_rsp_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(a_req_ready), 32'd1);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    a_req_valid = 0; a_req_write = 0; a_req_addr = 0; a_req_wdata = 0; a_req_be = 0; a_rsp_ready = 0;
    b_req_valid = 0; b_req_write = 0; b_req_addr = 0; b_req_wdata = 0; b_req_be = 0; b_rsp_ready = 0;

    // Reset state
    @(negedge clk);
    check("rst_req_ready", 32'(a_req_ready), 32'd0);
    check("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
    check("rst_rsp_rdata", a_rsp_rdata, 32'd0);
    check("rst_rsp_error", 32'(a_rsp_error), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(a_req_ready), 32'd1);

    // Test 1: full-word store then load
    do_req("t1_st", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
    do_req("t1_ld", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

    // Test 2: partial and empty byte enables
    do_req("t2_st_b0", 1'b1, 32'h10, 32'h000000AA, 4'h1, 32'h0, 1'b0);
    do_req("t2_ld_b0", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0);
    do_req("t2_st_be0", 1'b1, 32'h10, 32'h12345678, 4'h0, 32'h0, 1'b0);
    do_req("t2_ld_be0", 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEAA, 1'b0);

    // Test 3: error cases, none of which may touch the array
    do_req("t3_st_w0", 1'b1, 32'h0, 32'h01234567, 4'hF, 32'h0, 1'b0);
    do_req("t3_ld_mis", 1'b0, 32'h13, 32'h0, 4'hF, 32'h0, 1'b1);
    do_req("t3_st_mis", 1'b1, 32'h402, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
    do_req("t3_st_mis12", 1'b1, 32'h12, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
    do_req("t3_ld_oor", 1'b0, 32'h400, 32'h0, 4'hF, 32'h0, 1'b1);
    do_req("t3_ld_top", 1'b0, 32'hFFFFFFFC, 32'h0, 4'hF, 32'h0, 1'b1);
    do_req("t3_st_oor", 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
    do_req("t3_ld_w0", 1'b0, 32'h0, 32'h0, 4'hF, 32'h01234567, 1'b0);
    do_req("t3_ld_w4", 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEAA, 1'b0);
    do_req("t3_ld_last", 1'b1, 32'h3FC, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0);
    do_req("t3_ld_lastr", 1'b0, 32'h3FC, 32'h0, 4'hF, 32'hA5A5A5A5, 1'b0);

    // Test 4: response back-pressure with a second request held pending
    a_req_write = 1'b0; a_req_addr = 32'h10; a_req_be = 4'hF;
    a_req_valid = 1'b1; a_rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    a_req_addr = 32'h0;
    n = 0;
    while (!a_rsp_valid && n < LIMIT) begin @(negedge clk); n++; end
    check("t4_latency", 32'(n), 32'd3);
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_valid", 32'(a_rsp_valid), 32'd1);
      check("t4_hold_rdata", a_rsp_rdata, 32'hDEADBEAA);
      check("t4_hold_error", 32'(a_rsp_error), 32'd0);
      check("t4_hold_ready", 32'(a_req_ready), 32'd0);
      @(negedge clk);
    end
    a_rsp_ready = 1'b1;
    check("t4_last_valid", 32'(a_rsp_valid), 32'd1);
    check("t4_last_ready", 32'(a_req_ready), 32'd0);
    @(negedge clk);
    check("t4_after_valid", 32'(a_rsp_valid), 32'd0);
    check("t4_after_ready", 32'(a_req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    a_req_valid = 1'b0;
    n = 0;
    while (!a_rsp_valid && n < LIMIT) begin @(negedge clk); n++; end
    check("t4_second_latency", 32'(n), 32'd3);
    check("t4_second_rdata", a_rsp_rdata, 32'h01234567);
    @(negedge clk);

    // Test 5: zero wait states, request held valid; store then back-to-back loads
    b_req_write = 1'b1; b_req_addr = 32'h8; b_req_wdata = 32'hCAFEF00D; b_req_be = 4'hF;
    b_req_valid = 1'b1; b_rsp_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      check("t5_ready", 32'(b_req_ready), 32'((k % 3) == 0));
      check("t5_valid", 32'(b_rsp_valid), 32'((k % 3) == 2));
      if ((k % 3) == 2) check("t5_rdata", b_rsp_rdata, (k == 2) ? 32'h0 : 32'hCAFEF00D);
      if (k == 2) b_req_write = 1'b0;
      if (k == 11) b_req_valid = 1'b0;
      @(negedge clk);
    end
    check("t5_idle_valid", 32'(b_rsp_valid), 32'd0);

    // Test 6: reset during WAIT drops the store
    do_req("t6_pre", 1'b1, 32'h20, 32'h11111111, 4'hF, 32'h0, 1'b0);
    a_req_write = 1'b1; a_req_addr = 32'h20; a_req_wdata = 32'h55; a_req_be = 4'hF;
    a_req_valid = 1'b1; a_rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t6_in_wait_ready", 32'(a_req_ready), 32'd0);
    rst = 1'b1;
    #1;
    check("t6_rst_ready", 32'(a_req_ready), 32'd0);
    check("t6_rst_valid", 32'(a_rsp_valid), 32'd0);
    check("t6_rst_rdata", a_rsp_rdata, 32'd0);
    check("t6_rst_error", 32'(a_rsp_error), 32'd0);
    a_req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_req("t6_ld", 1'b0, 32'h20, 32'h0, 4'hF, 32'h11111111, 1'b0);

    // Reset while a load response is pending clears outputs at once
    a_req_write = 1'b0; a_req_addr = 32'h10; a_req_valid = 1'b1; a_rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    a_req_valid = 1'b0;
    n = 0;
    while (!a_rsp_valid && n < LIMIT) begin @(negedge clk); n++; end
    check("t6b_pending_rdata", a_rsp_rdata, 32'hDEADBEAA);
    rst = 1'b1;
    #1;
    check("t6b_rst_valid", 32'(a_rsp_valid), 32'd0);
    check("t6b_rst_rdata", a_rsp_rdata, 32'd0);
    check("t6b_rst_ready", 32'(a_req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6b_post_ready", 32'(a_req_ready), 32'd1);
    do_req("t6b_ld", 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEAA, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
